// File: rtl/zbuffer_writer.sv
// zbuffer_writer: depth-tested fragment sink writing colors to an SDRAM frame buffer
// Ports: clock, reset (async, active-high); frag_addr/frag_color/frag_depth/frag_valid in and
// frag_stall out form the rasterizer handshake; done_in/done_out flag end of triangle;
// mem_* is a single Avalon-MM master; pass_count/reject_count are saturating statistics.
// Build option ZBUF_DEPTH_TEST_EN: enables the z-buffer read-compare-write path; without it every
// fragment goes straight to the frame buffer and reject_count stays 0.
module zbuffer_writer #(
    parameter int ADDR_W = 26,
    parameter logic [ADDR_W-1:0] DEPTH_OFFSET = ADDR_W'(26'h080000),
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] frag_addr,
    input  logic [23:0]       frag_color,
    input  logic [31:0]       frag_depth,
    input  logic              frag_valid,
    output logic              frag_stall,
    input  logic              done_in,
    output logic              done_out,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    input  logic              mem_waitrequest,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  reject_count
);
    localparam logic [2:0] IDLE = 3'd0;
`ifdef ZBUF_DEPTH_TEST_EN
    localparam logic [2:0] ZREAD = 3'd1;
    localparam logic [2:0] ZWAIT = 3'd2;
    localparam logic [2:0] CMP = 3'd3;
    localparam logic [2:0] ZWRITE = 3'd4;
`endif
    localparam logic [2:0] CWRITE = 3'd5;
    logic [2:0] state;
`ifdef ZBUF_DEPTH_TEST_EN
    logic [ADDR_W-1:0] hold_addr;
    logic [23:0] hold_color;
    logic [31:0] hold_depth;
    logic [31:0] z_depth;
`else
    logic unused_inputs;
    assign unused_inputs = ^{frag_depth, mem_readdata, mem_readdatavalid};
    assign reject_count = '0;
`endif
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            frag_stall <= 1'b0;
            done_out <= 1'b0;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_address <= '0;
            mem_writedata <= '0;
            pass_count <= '0;
`ifdef ZBUF_DEPTH_TEST_EN
            reject_count <= '0;
            hold_addr <= '0;
            hold_color <= '0;
            hold_depth <= '0;
            z_depth <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (frag_valid) begin
                        frag_stall <= 1'b1;
                        done_out <= 1'b0;
`ifdef ZBUF_DEPTH_TEST_EN
                        hold_addr <= frag_addr;
                        hold_color <= frag_color;
                        hold_depth <= frag_depth;
                        state <= ZREAD;
                        mem_read <= 1'b1;
                        mem_address <= frag_addr + DEPTH_OFFSET;
`else
                        state <= CWRITE;
                        mem_write <= 1'b1;
                        mem_address <= frag_addr;
                        mem_writedata <= {8'h00, frag_color};
`endif
                    end else if (done_in) begin
                        done_out <= 1'b1;
                    end
                end
`ifdef ZBUF_DEPTH_TEST_EN
                ZREAD: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        state <= ZWAIT;
                    end
                end
                ZWAIT: begin
                    if (mem_readdatavalid) begin
                        z_depth <= mem_readdata;
                        state <= CMP;
                    end
                end
                CMP: begin
                    // mem_address still holds the depth address from ZREAD
                    if (hold_depth < z_depth) begin
                        state <= ZWRITE;
                        mem_write <= 1'b1;
                        mem_writedata <= hold_depth;
                    end else begin
                        state <= IDLE;
                        frag_stall <= 1'b0;
                        if (!(&reject_count)) reject_count <= reject_count + CNT_W'(1);
                    end
                end
                ZWRITE: begin
                    if (!mem_waitrequest) begin
                        state <= CWRITE;
                        mem_address <= hold_addr;
                        mem_writedata <= {8'h00, hold_color};
                    end
                end
`endif
                CWRITE: begin
                    if (!mem_waitrequest) begin
                        state <= IDLE;
                        mem_write <= 1'b0;
                        frag_stall <= 1'b0;
                        if (!(&pass_count)) pass_count <= pass_count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
